// File: rtl/sample_capture_buffer.sv
// sample_capture_buffer
//   Ping-pong capture buffer for a bar-graph display. Incoming samples are
//   decimated and armed on a rising-edge trigger (or auto-trigger after 512
//   samples without one). Each captured frame of 512 samples fills the back
//   bank. The bank is swapped to the front on a vsync falling edge once the
//   frame is complete and freeze is low.
//
// Parameters
//   DECIM       keep one of every DECIM accepted samples (1..255)
//   TRIG_LEVEL  rising-edge trigger threshold (8-bit unsigned)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   sample_in    8-bit unsigned sample, qualified by sample_valid
//   sample_valid one-cycle strobe for sample_in
//   vsync        active-low frame sync; frame boundary is its 1->0 edge
//   freeze       inhibits bank swaps while high
//   address      display read column 0..511
//   len          registered bar height, len(t+1) = front[address(t)]
//   frame_done   one-cycle pulse on each bank swap
//   state_dbg    FSM state (0=ARM, 1=FILL, 2=FULL)
module sample_capture_buffer #(
  parameter int unsigned DECIM      = 1,
  parameter int unsigned TRIG_LEVEL = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       vsync,
  input  logic       freeze,
  input  logic [8:0] address,
  output logic [7:0] len,
  output logic       frame_done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    BAD  = 2'd3
  } state_t;

  localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);
  localparam logic [7:0] TRIG     = 8'(TRIG_LEVEL);

  state_t     state;
  logic       bank_sel;      // front bank index; back bank is ~bank_sel
  logic       front_valid;
  logic [8:0] wr_ptr;
  logic [7:0] dcnt;
  logic [8:0] tcnt;
  logic [7:0] prev;
  logic       vsync_q;

  logic [7:0] mem [0:1][0:511];

  logic       accept;
  logic       vs_fall;
  logic       trig_hit;
  logic       auto_hit;
  logic       we;
  logic [8:0] waddr;

  assign accept   = sample_valid && (dcnt == DEC_LAST);
  assign vs_fall  = vsync_q && !vsync;
  assign trig_hit = (prev < TRIG) && (sample_in >= TRIG);
  assign auto_hit = (tcnt == 9'd511);

  always_comb begin
    we    = 1'b0;
    waddr = wr_ptr;
    case (state)
      ARM: begin
        if (accept && (trig_hit || auto_hit)) begin
          we    = 1'b1;
          waddr = '0;
        end
      end
      FILL: begin
        if (accept) we = 1'b1;
      end
      default: ;
    endcase
    if (rst) we = 1'b0;
  end

  // Memory has no reset; stale contents are masked by front_valid.
  always_ff @(posedge clk) begin
    if (we) mem[!bank_sel][waddr] <= sample_in;
  end

  // Read uses the pre-edge bank_sel, so a read coinciding with a swap
  // returns data from the outgoing front bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      len <= '0;
    end else begin
      len <= front_valid ? mem[bank_sel][address] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARM;
      bank_sel    <= 1'b0;
      front_valid <= 1'b0;
      wr_ptr      <= '0;
      dcnt        <= '0;
      tcnt        <= '0;
      prev        <= '0;
      vsync_q     <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_done <= 1'b0;

      if (sample_valid) begin
        dcnt <= (dcnt == DEC_LAST) ? '0 : dcnt + 8'd1;
      end

      case (state)
        ARM: begin
          if (accept) begin
            prev <= sample_in;
            if (trig_hit || auto_hit) begin
              state  <= FILL;
              wr_ptr <= 9'd1;
            end else begin
              tcnt <= tcnt + 9'd1;
            end
          end
        end
        FILL: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 9'd1;
            if (wr_ptr == 9'd511) state <= FULL;
          end
        end
        FULL: begin
          if (vs_fall && !freeze) begin
            bank_sel    <= !bank_sel;
            front_valid <= 1'b1;
            frame_done  <= 1'b1;
            tcnt        <= '0;
            prev        <= '0;
            wr_ptr      <= '0;
            state       <= ARM;
          end
        end
        default: begin
          state  <= ARM;
          wr_ptr <= '0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sample_capture_buffer.sv
module tb_sample_capture_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       vsync;
  logic       freeze;
  logic [8:0] address;
  logic [7:0] len1, len4;
  logic       fd1, fd4;
  logic [1:0] st1, st4;

  int total = 0;
  int bad   = 0;
  int fd1_cnt = 0;
  int fd4_cnt = 0;
  int rix = 0;
  bit ramp_mode = 1'b1;
  logic [7:0] cval = '0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  sample_capture_buffer #(.DECIM(1), .TRIG_LEVEL(128)) dut1 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .vsync(vsync), .freeze(freeze), .address(address),
    .len(len1), .frame_done(fd1), .state_dbg(st1)
  );

  sample_capture_buffer #(.DECIM(4), .TRIG_LEVEL(128)) dut4 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .vsync(vsync), .freeze(freeze), .address(address),
    .len(len4), .frame_done(fd4), .state_dbg(st4)
  );

  always @(negedge clk) begin
    if (fd1 === 1'b1) fd1_cnt++;
    if (fd4 === 1'b1) fd4_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      sample_in    = ramp_mode ? 8'(rix) : cval;
      sample_valid = 1'b1;
      rix++;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic rd(input bit sel4, input int a, input int e);
    logic [7:0] got;
    exp_q.push_back(8'(e));
    address = 9'(a);
    tick();
    got = sel4 ? len4 : len1;
    chk(sel4 ? "len4" : "len1", got, exp_q.pop_front());
  endtask

  // Falling vsync edge; optionally checks the read issued in the swap cycle.
  task automatic vs_edge(input bit do_rd, input int a, input int e);
    logic [7:0] got;
    address = 9'(a);
    vsync = 1'b0;
    if (do_rd) exp_q.push_back(8'(e));
    tick();
    if (do_rd) begin
      got = len1;
      chk("swap_read", got, exp_q.pop_front());
    end
    vsync = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_full(input bit sel4, input int budget);
    int n = 0;
    while ((sel4 ? st4 : st1) !== 2'd2 && n < budget) begin
      feed(1);
      n++;
    end
    chk("wait_full", sel4 ? st4 : st1, 2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int f0;
    rst = 1'b1; sample_in = '0; sample_valid = 1'b0;
    vsync = 1'b1; freeze = 1'b0; address = '0;

    // Reset state
    do_reset();
    chk("rst_state", st1, 0);
    chk("rst_fd", fd1, 0);
    chk("rst_len", len1, 0);
    rd(0, 0, 0);
    rd(0, 511, 0);

    // Ramp, DECIM=1: trigger on sample 128, FULL after 640 samples
    rix = 0; ramp_mode = 1'b1;
    feed(639);
    chk("ramp_fill", st1, 1);
    feed(1);
    chk("ramp_full", st1, 2);
    rd(0, 5, 0);
    f0 = fd1_cnt;
    vs_edge(1'b1, 0, 0);
    chk("ramp_fd", fd1_cnt - f0, 1);
    chk("ramp_arm", st1, 0);
    rd(0, 0, 128);
    rd(0, 127, 255);
    rd(0, 128, 0);
    rd(0, 511, 127);

    // Constant below threshold: auto-trigger after 512, FULL after 511 more
    ramp_mode = 1'b0; cval = 8'd100;
    feed(511);
    chk("auto_arm", st1, 0);
    feed(1);
    chk("auto_fill", st1, 1);
    feed(510);
    chk("auto_fill2", st1, 1);
    feed(1);
    chk("auto_full", st1, 2);

    // Freeze holds the old frame through three edges
    freeze = 1'b1;
    f0 = fd1_cnt;
    for (int k = 0; k < 3; k++) vs_edge(1'b0, 0, 0);
    chk("frz_fd", fd1_cnt - f0, 0);
    chk("frz_state", st1, 2);
    rd(0, 0, 128);
    rd(0, 300, 172);
    freeze = 1'b0;
    tick();
    vs_edge(1'b1, 0, 128);
    chk("unfrz_fd", fd1_cnt - f0, 1);
    for (int a = 0; a < 512; a++) rd(0, a, 100);

    // Constant 200 frame: all columns read 200
    cval = 8'd200;
    wait_full(0, 1100);
    f0 = fd1_cnt;
    vs_edge(1'b0, 0, 0);
    chk("c200_fd", fd1_cnt - f0, 1);
    for (int a = 0; a < 512; a++) rd(0, a, 200);

    // DECIM=4: accepted raw indices 4k+3, trigger on 131
    do_reset();
    rix = 0; ramp_mode = 1'b1;
    feed(1000);
    chk("d4_fill", st4, 1);
    f0 = fd4_cnt;
    vs_edge(1'b0, 0, 0);
    vs_edge(1'b0, 0, 0);
    chk("d4_nofd", fd4_cnt - f0, 0);
    chk("d4_fill2", st4, 1);
    feed(1175);
    chk("d4_fill3", st4, 1);
    feed(1);
    chk("d4_full", st4, 2);
    vs_edge(1'b0, 0, 0);
    chk("d4_fd", fd4_cnt - f0, 1);
    for (int a = 0; a < 512; a++) rd(1, a, (131 + 4 * a) & 255);

    // Reset mid-FILL at wr_ptr=300, then a full recapture
    do_reset();
    rix = 0;
    feed(428);
    chk("mid_fill", st1, 1);
    f0 = fd1_cnt;
    do_reset();
    chk("mid_rst_state", st1, 0);
    rd(0, 0, 0);
    rix = 0;
    feed(640);
    chk("re_full", st1, 2);
    vs_edge(1'b0, 0, 0);
    chk("re_fd", fd1_cnt - f0, 1);
    for (int a = 0; a < 512; a++) rd(0, a, (128 + a) & 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
